// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder at the far end of the pipeline memory port.
// Accepts one load/store at a time and completes it `latency` cycles after accept.
// It answers with a one-cycle mem_in_done pulse and a registered load_data.
// Ports: clk, rst (async, active-high), mem_addr/mem_data (request address/data),
//        load_flag/store_flag (request), mem_in_done (completion pulse),
//        load_data (load result), err_cnt (only when DMEM_ERR_CNT_EN is defined).
// Optional feature macro: DMEM_ERR_CNT_EN adds a saturating 8-bit error counter.
// It counts accepted requests that have both flags set or an address above the array range.
module data_mem_responder #(
  parameter int register_width = 32,
  parameter int depth          = 32,
  parameter int addr_bits      = 5,
  parameter int latency        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [register_width-1:0] mem_addr,
  input  logic [register_width-1:0] mem_data,
  input  logic                      load_flag,
  input  logic                      store_flag,
  output logic                      mem_in_done,
`ifdef DMEM_ERR_CNT_EN
  output logic [7:0]                err_cnt,
`endif
  output logic [register_width-1:0] load_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(latency - 1);

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [addr_bits-1:0]        idx_q, idx_d;
  logic [register_width-1:0]   data_q, data_d;
  logic                        store_q, store_d;
  logic [register_width-1:0]   load_data_q, load_data_d;
  logic                        done_q, done_d;
  logic [register_width-1:0]   mem_q [depth];
  logic [register_width-1:0]   mem_d [depth];
  logic                        accept;

  // Upper address bits only matter to the optional error counter.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[register_width-1:addr_bits];

  assign accept = (state_q == IDLE) && (load_flag || store_flag);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    store_d     = store_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    mem_d       = mem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = mem_addr[addr_bits-1:0];
          data_d  = mem_data;
          store_d = store_flag;  // store wins when both flags are high
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access happens on the same edge that enters DONE.
          state_d = DONE;
          done_d  = 1'b1;
          if (store_q) mem_d[idx_q] = data_q;
          else         load_data_d  = mem_q[idx_q];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      data_q      <= '0;
      store_q     <= 1'b0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      store_q     <= store_d;
      load_data_q <= load_data_d;
      done_q      <= done_d;
      for (int i = 0; i < depth; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign mem_in_done = done_q;
  assign load_data   = load_data_q;

`ifdef DMEM_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       req_err;

  // One increment per request, even when both error conditions hold.
  assign req_err = (load_flag && store_flag) ||
                   (mem_addr[register_width-1:addr_bits] != '0);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && req_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        load_flag = 1'b0;
  logic        store_flag = 1'b0;
  logic        mem_in_done;
  logic [31:0] load_data;
`ifdef DMEM_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  data_mem_responder #(.register_width(32), .depth(32), .addr_bits(5), .latency(LAT)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .load_flag(load_flag), .store_flag(store_flag), .mem_in_done(mem_in_done),
`ifdef DMEM_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: plain word array, last loaded value, error count.
  logic [31:0] model_mem [32];
  logic [31:0] model_ld = '0;
  int          model_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    model_ld = '0;
    model_err = 0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && mem_in_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("load_data", load_data, e.data);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one request, hold flags until done, drop them right after the DONE cycle.
  task automatic req(input bit ld, input bit st, input logic [31:0] addr,
                     input logic [31:0] data, input bit scramble);
    int idx;
    bit seen;
    @(negedge clk);
    load_flag = ld; store_flag = st; mem_addr = addr; mem_data = data;
    idx = int'(addr % 32);
    if (st) model_mem[idx] = data;
    else    model_ld = model_mem[idx];
    if ((ld && st) || (addr >= 32)) model_err = (model_err < 255) ? model_err + 1 : 255;
    exp_q.push_back('{data: model_ld, cyc: cyc + 1 + LAT});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_in_done) seen = 1'b1;
      else if (scramble) begin mem_addr = $urandom; mem_data = $urandom; end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done by cycle %0d", cyc);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    load_flag = 1'b0; store_flag = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check("rst_done", {31'd0, mem_in_done}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Store then loads, including an untouched word.
    req(1'b0, 1'b1, 32'd3, 32'hDEADBEEF, 1'b0);
    check("store_keeps_ld", load_data, 32'd0);
    req(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'd4, 32'h0, 1'b0);
    // Both flags: store wins.
    req(1'b1, 1'b1, 32'd5, 32'h12345678, 1'b0);
    req(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
    // Address wrap.
    req(1'b0, 1'b1, 32'd35, 32'hA5A5A5A5, 1'b0);
    req(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
    // Inputs change during BUSY; captured values must be used.
    req(1'b0, 1'b1, 32'd9, 32'h0BADF00D, 1'b1);
    req(1'b1, 1'b0, 32'd9, 32'h0, 1'b1);
    check("ld_stable", load_data, 32'h0BADF00D);

`ifdef DMEM_ERR_CNT_EN
    check("err_cnt_mid", {24'd0, err_cnt}, 32'(model_err));
`endif

    // Reset during BUSY of a store to 7: no done, outputs cleared, no write.
    @(negedge clk);
    store_flag = 1'b1; mem_addr = 32'd7; mem_data = 32'h1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_done", {31'd0, mem_in_done}, 32'd0);
    check("abort_load_data", load_data, 32'd0);
    @(negedge clk);
    store_flag = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    req(1'b1, 1'b0, 32'd7, 32'h0, 1'b0);

    // Randomized traffic over a small address window so loads hit stores.
    for (int n = 0; n < 60; n++) begin
      int    k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = {($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'd0, 5'($urandom_range(0, 7))};
      if (k < 4)       req(1'b0, 1'b1, a, $urandom, k[0]);
      else if (k < 9)  req(1'b1, 1'b0, a, $urandom, k[0]);
      else             req(1'b1, 1'b1, a, $urandom, 1'b0);
    end

`ifdef DMEM_ERR_CNT_EN
    check("err_cnt_end", {24'd0, err_cnt}, 32'(model_err));
`endif
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
